// File: rtl/uart_scoreboard.sv
// UART receive checker: deserialises frames from a monitored TX line, compares them
// against a preloaded expectation list and reports a single pass/fail verdict.
module uart_scoreboard #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int MSB_FIRST    = 0,
    parameter int DEPTH        = 128,
    parameter int QUIET_CLKS   = 1000,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic                         i_exp_we,
    input  logic [$clog2(DEPTH)-1:0]     i_exp_addr,
    input  logic [DATA_BITS:0]           i_exp_data,
    input  logic                         i_start,
    input  logic                         i_uart,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_pass,
    output logic                         o_err_mismatch,
    output logic                         o_err_frame,
    output logic                         o_err_unexp,
    output logic                         o_err_timeout,
    output logic [$clog2(DEPTH+1)-1:0]   o_rx_count,
    output logic [DATA_BITS-1:0]         o_rx_data,
    output logic                         o_rx_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int DW = $clog2(DATA_BITS + 1);
    localparam int QW = $clog2(QUIET_CLKS + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [BW-1:0] BIT_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST  = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DW-1:0] DBIT_LAST  = DW'(DATA_BITS - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CLKS - 1);
    localparam logic [TW-1:0] TO_LIM     = TW'(TIMEOUT_CLKS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WAIT, S_RX_START, S_RX_DATA, S_RX_STOP, S_QUIET, S_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic                 r_sync1, r_sync2, r_sync_prev;
    logic [BW-1:0]        r_clk_cnt;
    logic [DW-1:0]        r_bit_cnt;
    logic [QW-1:0]        r_q_cnt;
    logic [TW-1:0]        r_to_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [CW-1:0]        r_rx_count;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_err_mismatch, r_err_frame, r_err_unexp, r_err_timeout;
    logic [DATA_BITS:0]   r_mem [DEPTH];
    logic [DATA_BITS:0]   r_rd_data;

    logic                 w_busy, w_fall, w_bit_tick, w_half_tick, w_stop_tick;
    logic                 w_timeout, w_start_cmd, w_quiet_tick, w_mem_we;
    logic [AW-1:0]        w_rd_addr;
    logic [DATA_BITS-1:0] w_shift_next;

    assign w_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_fall       = r_sync_prev & ~r_sync2;
    assign w_bit_tick   = (r_clk_cnt == BIT_LAST);
    assign w_half_tick  = (r_clk_cnt == HALF_LAST);
    assign w_stop_tick  = (r_state == S_RX_STOP) && w_bit_tick;
    assign w_timeout    = w_busy && (r_to_cnt == TO_LIM);
    assign w_start_cmd  = i_start && !w_busy;
    assign w_quiet_tick = (r_state == S_QUIET) && (r_q_cnt == QUIET_LAST);
    assign w_mem_we     = i_exp_we && !w_busy;

    // The received-frame count doubles as the expectation pointer; read address
    // follows its next value so LOOKUP sees the fresh entry.
    assign w_rd_addr = w_start_cmd ? '0 :
                       w_stop_tick ? AW'(r_rx_count + CW'(1)) : AW'(r_rx_count);

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shift[DATA_BITS-2:0], r_sync2};
        end else begin : g_lsb_first
            assign w_shift_next = {r_sync2, r_shift[DATA_BITS-1:1]};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (w_mem_we)
            r_mem[i_exp_addr] <= i_exp_data;
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_state_next = S_LOOKUP;
            S_LOOKUP:   w_state_next = r_rd_data[DATA_BITS] ? S_WAIT : S_QUIET;
            S_WAIT:     if (w_fall) w_state_next = S_RX_START;
            S_RX_START: if (w_half_tick) w_state_next = r_sync2 ? S_WAIT : S_RX_DATA;
            S_RX_DATA:  if (w_bit_tick && r_bit_cnt == DBIT_LAST) w_state_next = S_RX_STOP;
            S_RX_STOP:  if (w_bit_tick) w_state_next = (r_rx_count == CNT_LAST) ? S_QUIET : S_LOOKUP;
            S_QUIET:    if (w_fall || w_quiet_tick) w_state_next = S_DONE;
            default:    w_state_next = S_IDLE;
        endcase
        if (w_timeout)
            w_state_next = S_DONE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_sync1        <= 1'b1;
            r_sync2        <= 1'b1;
            r_sync_prev    <= 1'b1;
            r_clk_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_q_cnt        <= '0;
            r_to_cnt       <= '0;
            r_shift        <= '0;
            r_rx_count     <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_err_mismatch <= 1'b0;
            r_err_frame    <= 1'b0;
            r_err_unexp    <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_sync1     <= i_uart;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_rx_valid  <= 1'b0;

            // Bit timer restarts on every state change and at each bit boundary.
            if (w_state_next != r_state || w_bit_tick)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + BW'(1);

            if (r_state == S_QUIET)
                r_q_cnt <= r_q_cnt + QW'(1);
            else
                r_q_cnt <= '0;

            if (w_start_cmd)
                r_to_cnt <= '0;
            else if (w_busy)
                r_to_cnt <= r_to_cnt + TW'(1);

            if (r_state == S_RX_START) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_RX_DATA && w_bit_tick) begin
                r_bit_cnt <= r_bit_cnt + DW'(1);
                r_shift   <= w_shift_next;
            end

            if (w_start_cmd) begin
                r_rx_count     <= '0;
                r_err_mismatch <= 1'b0;
                r_err_frame    <= 1'b0;
                r_err_unexp    <= 1'b0;
                r_err_timeout  <= 1'b0;
            end

            if (w_stop_tick) begin
                if (!r_sync2)
                    r_err_frame <= 1'b1;
                if (r_shift != r_rd_data[DATA_BITS-1:0])
                    r_err_mismatch <= 1'b1;
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_shift;
                r_rx_count <= r_rx_count + CW'(1);
            end

            if (w_timeout)
                r_err_timeout <= 1'b1;
            if (r_state == S_QUIET && w_fall && !w_timeout)
                r_err_unexp <= 1'b1;
        end
    end

    assign o_busy         = w_busy;
    assign o_done         = (r_state == S_DONE);
    assign o_pass         = o_done && !(r_err_mismatch || r_err_frame || r_err_unexp || r_err_timeout);
    assign o_err_mismatch = r_err_mismatch;
    assign o_err_frame    = r_err_frame;
    assign o_err_unexp    = r_err_unexp;
    assign o_err_timeout  = r_err_timeout;
    assign o_rx_count     = r_rx_count;
    assign o_rx_data      = r_rx_data;
    assign o_rx_valid     = r_rx_valid;
endmodule
